// File: rtl/uart_pkg.sv
// Shared UART definitions: RxCore one-hot state codes, parity method/enable
// encodings and the parity checker's internal FSM type.
package uart_pkg;

    localparam logic [4:0] RX_INTERVAL  = 5'b00001;
    localparam logic [4:0] RX_STARTBIT  = 5'b00010;
    localparam logic [4:0] RX_DATABITS  = 5'b00100;
    localparam logic [4:0] RX_PARITYBIT = 5'b01000;
    localparam logic [4:0] RX_STOPBIT   = 5'b10000;

    localparam logic EVEN    = 1'b0;
    localparam logic ODD     = 1'b1;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_ACCUM = 2'd1,
        CHK_CHECK = 2'd2
    } chk_state_t;

    // True when exactly one bit of the RxCore state vector is set.
    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'b00000) && ((v & (v - 5'd1)) == 5'b00000);
    endfunction

endpackage

// File: rtl/parity_err_counter.sv
// 16-bit saturating event counter with synchronous clear (clear beats increment).
module parity_err_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clear,
    output logic [15:0] count
);

    logic [15:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 16'h0000;
        end else if (clear) begin
            count_reg <= 16'h0000;
        end else if (inc && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'h0001;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rx_parity_checker.sv
// Receive-side parity checker tracking the RxCore one-hot state and sample strobe.
// Optional saturating error counter enabled by defining RX_PARITY_ERRCNT_EN.
module rx_parity_checker
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  State_i,
    input  logic        p_BitSample_i,
    input  logic        RxBit_i,
    input  logic        ParityEnable_i,
    input  logic        ParityMethod_i,
    output logic        ParityError_o,
    output logic        p_ParityDone_o
`ifdef RX_PARITY_ERRCNT_EN
    ,
    input  logic        ErrCntClear_i,
    output logic [15:0] ErrorCount_o
`endif
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_BITS);

    chk_state_t state_reg;
    logic       acc_reg;
    logic [3:0] cnt_reg;
    logic       en_reg;
    logic       method_reg;
    logic       err_reg;
    logic       done_reg;

    logic state_valid;
    logic frame_error;

    assign state_valid = is_onehot5(State_i);
    // A missing data bit is reported as a parity error as well.
    assign frame_error = (RxBit_i != (acc_reg ^ method_reg)) || (cnt_reg != FULL_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= CHK_IDLE;
            acc_reg    <= 1'b0;
            cnt_reg    <= 4'd0;
            en_reg     <= DISABLE;
            method_reg <= EVEN;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!state_valid) begin
                state_reg <= CHK_IDLE;
            end else if (State_i == RX_STARTBIT) begin
                // Any start bit resynchronises onto a fresh frame.
                state_reg  <= CHK_ACCUM;
                acc_reg    <= 1'b0;
                cnt_reg    <= 4'd0;
                en_reg     <= ParityEnable_i;
                method_reg <= ParityMethod_i;
                err_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    CHK_ACCUM: begin
                        if (State_i == RX_PARITYBIT) begin
                            // A sample landing on the transition cycle is the parity bit.
                            if (p_BitSample_i) begin
                                state_reg <= CHK_IDLE;
                                if (en_reg == ENABLE) begin
                                    err_reg  <= frame_error;
                                    done_reg <= 1'b1;
                                end
                            end else begin
                                state_reg <= CHK_CHECK;
                            end
                        end else if ((State_i == RX_DATABITS) && p_BitSample_i
                                     && (cnt_reg != FULL_CNT)) begin
                            acc_reg <= acc_reg ^ RxBit_i;
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                    CHK_CHECK: begin
                        if (State_i != RX_PARITYBIT) begin
                            state_reg <= CHK_IDLE;
                        end else if (p_BitSample_i) begin
                            state_reg <= CHK_IDLE;
                            if (en_reg == ENABLE) begin
                                err_reg  <= frame_error;
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= CHK_IDLE;
                    end
                endcase
            end
        end
    end

    assign ParityError_o  = err_reg;
    assign p_ParityDone_o = done_reg;

`ifdef RX_PARITY_ERRCNT_EN
    parity_err_counter u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (done_reg & err_reg),
        .clear (ErrCntClear_i),
        .count (ErrorCount_o)
    );
`endif

endmodule

// File: tb/tb_rx_parity_checker.sv
// Directed table-driven bench for rx_parity_checker, plus hand-written
// sequences for reset, resync and abort cases (error counter under RX_PARITY_ERRCNT_EN).
module tb_rx_parity_checker;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] State_i = RX_INTERVAL;
    logic       p_BitSample_i = 1'b0;
    logic       RxBit_i = 1'b1;
    logic       ParityEnable_i = 1'b0;
    logic       ParityMethod_i = 1'b0;
    logic       ParityError_o;
    logic       p_ParityDone_o;
`ifdef RX_PARITY_ERRCNT_EN
    logic        ErrCntClear_i = 1'b0;
    logic [15:0] ErrorCount_o;
`endif

    rx_parity_checker #(.DATA_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .State_i        (State_i),
        .p_BitSample_i  (p_BitSample_i),
        .RxBit_i        (RxBit_i),
        .ParityEnable_i (ParityEnable_i),
        .ParityMethod_i (ParityMethod_i),
        .ParityError_o  (ParityError_o),
        .p_ParityDone_o (p_ParityDone_o)
`ifdef RX_PARITY_ERRCNT_EN
        ,
        .ErrCntClear_i  (ErrCntClear_i),
        .ErrorCount_o   (ErrorCount_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       en_mid;
        logic       meth;
        logic       meth_mid;
        logic [7:0] data;
        int         nbits;
        logic       pbit;
        int         exp_pulses;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   pulse_cnt = 0;

    // Cycles with the done pulse high; a pulse wider than one cycle counts twice.
    always @(negedge clk) begin
        if (p_ParityDone_o === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one clock cycle of RxCore activity; returns on the following falling edge.
    task automatic cyc(input logic [4:0] st, input logic s, input logic b);
        State_i       = st;
        p_BitSample_i = s;
        RxBit_i       = b;
        @(negedge clk);
        p_BitSample_i = 1'b0;
    endtask

    task automatic start_and_data(input logic en, input logic en_mid, input logic meth,
                                  input logic meth_mid, input logic [7:0] data, input int nbits);
        ParityEnable_i = en;
        ParityMethod_i = meth;
        cyc(RX_STARTBIT, 1'b0, 1'b0);
        cyc(RX_STARTBIT, 1'b1, 1'b0);
        ParityEnable_i = en_mid;
        ParityMethod_i = meth_mid;
        for (int i = 0; i < nbits; i++) begin
            cyc(RX_DATABITS, 1'b1, data[i]);
            cyc(RX_DATABITS, 1'b0, 1'b0);
        end
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int p0;
        ParityEnable_i = v.en;
        ParityMethod_i = v.meth;
        cyc(RX_STARTBIT, 1'b0, 1'b0);
        cyc(RX_STARTBIT, 1'b1, 1'b0);
        check($sformatf("v%0d_start_clear", idx), {15'd0, ParityError_o}, 16'd0);
        p0 = pulse_cnt;
        ParityEnable_i = v.en_mid;
        ParityMethod_i = v.meth_mid;
        for (int i = 0; i < v.nbits; i++) begin
            cyc(RX_DATABITS, 1'b1, v.data[i]);
            cyc(RX_DATABITS, 1'b0, 1'b0);
        end
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b1, v.pbit);
        check($sformatf("v%0d_parity_err", idx), {15'd0, ParityError_o}, {15'd0, v.exp_err});
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_STOPBIT, 1'b1, 1'b1);
        cyc(RX_STOPBIT, 1'b0, 1'b1);
        cyc(RX_INTERVAL, 1'b0, 1'b1);
        check($sformatf("v%0d_err_hold", idx), {15'd0, ParityError_o}, {15'd0, v.exp_err});
        check($sformatf("v%0d_pulses", idx), 16'(pulse_cnt - p0), 16'(v.exp_pulses));
    endtask

    initial begin
        int p0;
        //                en    en_mid meth  meth_mid data   n  pbit  pulses err
        vecs[0] = '{1'b1, 1'b1, EVEN, EVEN, 8'hA5, 8, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, EVEN, EVEN, 8'hA5, 8, 1'b1, 1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, ODD,  ODD,  8'h07, 8, 1'b0, 1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, ODD,  ODD,  8'h07, 8, 1'b1, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, EVEN, EVEN, 8'hA5, 6, 1'b1, 1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, EVEN, EVEN, 8'hA5, 8, 1'b1, 0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, ODD,  EVEN, 8'hFF, 8, 1'b1, 1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, EVEN, EVEN, 8'h01, 8, 1'b0, 1, 1'b1};
        vecs[8] = '{1'b1, 1'b1, EVEN, EVEN, 8'h00, 8, 1'b0, 1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, ODD,  ODD,  8'h3C, 8, 1'b0, 1, 1'b1};

        @(negedge clk);
        @(negedge clk);
        check("reset_err", {15'd0, ParityError_o}, 16'd0);
        check("reset_done", {15'd0, p_ParityDone_o}, 16'd0);
`ifdef RX_PARITY_ERRCNT_EN
        check("reset_count", ErrorCount_o, 16'd0);
`endif
        rst = 1'b1;
        cyc(RX_INTERVAL, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_frame(i, vecs[i]);
        end

        // Asynchronous reset after a bad frame clears the held flag at once.
        run_frame(10, vecs[1]);
        #2 rst = 1'b0;
        #1 check("rst_idle_err", {15'd0, ParityError_o}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of DATABITS abandons the frame.
        p0 = pulse_cnt;
        start_and_data(1'b1, 1'b1, EVEN, EVEN, 8'h01, 3);
        #2 rst = 1'b0;
        #1 check("rst_mid_err", {15'd0, ParityError_o}, 16'd0);
        check("rst_mid_done", {15'd0, p_ParityDone_o}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) cyc(RX_DATABITS, 1'b1, 1'b0);
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b1, 1'b0);
        cyc(RX_STOPBIT, 1'b0, 1'b1);
        check("rst_abort_pulses", 16'(pulse_cnt - p0), 16'd0);
        check("rst_abort_err", {15'd0, ParityError_o}, 16'd0);
        run_frame(11, vecs[1]);
        run_frame(12, vecs[0]);

        // Non-one-hot state drops the frame: no check on the later parity sample.
        p0 = pulse_cnt;
        start_and_data(1'b1, 1'b1, EVEN, EVEN, 8'h01, 8);
        cyc(5'b00110, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b1, 1'b0);
        cyc(RX_STOPBIT, 1'b0, 1'b1);
        check("bad_state_pulses", 16'(pulse_cnt - p0), 16'd0);
        check("bad_state_err", {15'd0, ParityError_o}, 16'd0);

        // Leaving PARITYBIT without a sample produces no result.
        p0 = pulse_cnt;
        start_and_data(1'b1, 1'b1, EVEN, EVEN, 8'h01, 8);
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_STOPBIT, 1'b0, 1'b1);
        cyc(RX_STOPBIT, 1'b1, 1'b1);
        cyc(RX_INTERVAL, 1'b0, 1'b1);
        check("no_sample_pulses", 16'(pulse_cnt - p0), 16'd0);
        check("no_sample_err", {15'd0, ParityError_o}, 16'd0);

        // STARTBIT mid-data resynchronises: only the restarted frame is checked.
        p0 = pulse_cnt;
        start_and_data(1'b1, 1'b1, EVEN, EVEN, 8'hFF, 3);
        run_frame(13, vecs[0]);
        check("resync_pulses", 16'(pulse_cnt - p0), 16'd1);

`ifdef RX_PARITY_ERRCNT_EN
        // Counter was cleared by the mid-frame reset; one bad frame since (v11).
        check("cnt_after_rst", ErrorCount_o, 16'd1);
        run_frame(20, vecs[1]);
        run_frame(21, vecs[3]);
        check("cnt_three", ErrorCount_o, 16'd3);
        start_and_data(1'b1, 1'b1, EVEN, EVEN, 8'hA5, 8);
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        cyc(RX_PARITYBIT, 1'b1, 1'b1);
        check("cnt_clr_done", {15'd0, p_ParityDone_o}, 16'd1);
        ErrCntClear_i = 1'b1;
        cyc(RX_PARITYBIT, 1'b0, 1'b0);
        ErrCntClear_i = 1'b0;
        cyc(RX_STOPBIT, 1'b0, 1'b1);
        check("cnt_clear_wins", ErrorCount_o, 16'd0);
        force dut.u_err_counter.count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.u_err_counter.count_reg;
        run_frame(22, vecs[1]);
        check("cnt_saturate", ErrorCount_o, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
